// File: rtl/scratchpad_port_arbiter_pkg.sv
// Shared types and constants for the scratchpad port arbiter.
// FSM state encoding, default widths and the word-to-byte shift.
package scratchpad_pkg;

    localparam int DEF_ADDR_WID = 14;
    localparam int DEF_DATA_WID = 32;
    localparam int DEF_MEM_AW   = 64;
    localparam int WORD_SHIFT   = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1
    } arb_state_e;

endpackage

// File: rtl/scratchpad_port_arbiter_if.sv
// External memory channel: one request/response pair, single outstanding.
// master = arbiter side, slave = memory side.
interface scratchpad_port_arbiter_if #(
    parameter int DATA_WID = 32,
    parameter int MEM_AW   = 64
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_we;
    logic [MEM_AW-1:0]   mem_req_addr;
    logic [DATA_WID-1:0] mem_req_wdata;
    logic                mem_rsp_valid;
    logic [DATA_WID-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/scratchpad_port_arbiter_sat_counter.sv
// Saturating up-counter used for the host-visible statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             mod_clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);
    // count up on inc, hold at the maximum
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (inc && value != '1)
            value <= value + CNT_W'(1);
    end
endmodule

// File: rtl/scratchpad_port_arbiter.sv
// Serializes the kernel's two scratchpad ports onto one memory channel,
// port 0 first, stalling the kernel until all captured accesses finish.
module scratchpad_port_arbiter
    import scratchpad_pkg::*;
#(
    parameter int ADDR_WID = DEF_ADDR_WID,
    parameter int DATA_WID = DEF_DATA_WID,
    parameter int MEM_AW   = DEF_MEM_AW,
    parameter int CNT_W    = 32
) (
    input  logic                mod_clk,
    input  logic                reset,
    input  logic [MEM_AW-1:0]   base_addr,
    input  logic [ADDR_WID-1:0] addr0,
    input  logic                ce0,
    input  logic                we0,
    input  logic [DATA_WID-1:0] d0,
    output logic [DATA_WID-1:0] q0,
    input  logic [ADDR_WID-1:0] addr1,
    input  logic                ce1,
    input  logic                we1,
    input  logic [DATA_WID-1:0] d1,
    output logic [DATA_WID-1:0] q1,
    output logic                stall,
    scratchpad_port_arbiter_if.master mem,
    output logic [CNT_W-1:0]    access_count,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic                protocol_err
);
    arb_state_e          state, state_nx;
    logic                pend0, pend1;
    logic                lwe0, lwe1;
    logic [MEM_AW-1:0]   badr0, badr1;
    logic [DATA_WID-1:0] ld0, ld1;
    logic                capture, rsp0, rsp1, in_wait;

    assign capture = (state == IDLE) && (ce0 || ce1);
    assign rsp0    = (state == WAIT0) && mem.mem_rsp_valid;
    assign rsp1    = (state == WAIT1) && mem.mem_rsp_valid;
    assign in_wait = (state == WAIT0) || (state == WAIT1);

    // state register
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state: port 0 is always drained before port 1
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (ce0)
                    state_nx = ISSUE0;
                else if (ce1)
                    state_nx = ISSUE1;
            end
            ISSUE0:
                if (mem.mem_req_ready) state_nx = WAIT0;
            WAIT0:
                if (mem.mem_rsp_valid) state_nx = pend1 ? ISSUE1 : IDLE;
            ISSUE1:
                if (mem.mem_req_ready) state_nx = WAIT1;
            WAIT1:
                if (mem.mem_rsp_valid) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    // request outputs come from the latched port of the issuing state
    always_comb begin
        mem.mem_req_valid = 1'b0;
        mem.mem_req_we    = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_wdata = '0;
        unique case (state)
            ISSUE0: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_we    = lwe0;
                mem.mem_req_addr  = badr0;
                mem.mem_req_wdata = ld0;
            end
            ISSUE1: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_we    = lwe1;
                mem.mem_req_addr  = badr1;
                mem.mem_req_wdata = ld1;
            end
            default: ;
        endcase
    end

    // capture enabled ports; byte address is fixed at capture time
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            lwe0  <= 1'b0;
            lwe1  <= 1'b0;
            badr0 <= '0;
            badr1 <= '0;
            ld0   <= '0;
            ld1   <= '0;
        end else if (capture) begin
            pend0 <= ce0;
            pend1 <= ce1;
            if (ce0) begin
                lwe0  <= we0;
                badr0 <= base_addr + (MEM_AW'(addr0) << WORD_SHIFT);
                ld0   <= d0;
            end
            if (ce1) begin
                lwe1  <= we1;
                badr1 <= base_addr + (MEM_AW'(addr1) << WORD_SHIFT);
                ld1   <= d1;
            end
        end else begin
            if (rsp0) pend0 <= 1'b0;
            if (rsp1) pend1 <= 1'b0;
        end
    end

    // read data lands in q only for reads; writes leave q alone
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            if (rsp0 && !lwe0) q0 <= mem.mem_rsp_rdata;
            if (rsp1 && !lwe1) q1 <= mem.mem_rsp_rdata;
        end
    end

    // stall mirrors "busy next cycle", registered
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset)
            stall <= 1'b0;
        else
            stall <= (state_nx != IDLE);
    end

    // sticky flag for responses with nothing outstanding
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset)
            protocol_err <= 1'b0;
        else if (mem.mem_rsp_valid && !in_wait)
            protocol_err <= 1'b1;
    end

    sat_counter #(.CNT_W(CNT_W)) u_access_cnt (
        .mod_clk (mod_clk),
        .reset   (reset),
        .inc     (rsp0 || rsp1),
        .value   (access_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .mod_clk (mod_clk),
        .reset   (reset),
        .inc     (stall),
        .value   (stall_cycles)
    );
endmodule

// File: doc/scratchpad_port_arbiter.md
Name: scratchpad_port_arbiter

Overview:
- Sits between an HLS kernel's dual scratchpad ports (port 0 and port 1) and the single-outstanding external memory request channel.
- Captures the ports' requests and serializes them onto the memory channel, port 0 first.
- Holds the kernel via a stall/clock-enable output until every captured access completes.
- Returns read data on per-port q registers and keeps access and stall-cycle statistics for the host.

Parameters:
ADDR_WID, 14, kernel word-address width per port
DATA_WID, 32, data width
MEM_AW, 64, external byte-address width
CNT_W, 32, statistics counter width

Ports:
mod_clk  in  1  block clock; same clock the kernel runs on when not stalled
reset  in  1  asynchronous, active-high
base_addr  in  MEM_AW  byte base of scratchpad in external memory
addr0  in  ADDR_WID  port 0 word address
ce0  in  1  port 0 enable
we0  in  1  port 0 write
d0  in  DATA_WID  port 0 write data
q0  out  DATA_WID  port 0 read data
addr1, ce1, we1, d1, q1  same as port 0, for port 1
stall  out  1  kernel clock-enable inhibit (1 = hold kernel)
mem_req_valid  out  1  request valid
mem_req_ready  in  1  request accepted
mem_req_we  out  1  1 = write
mem_req_addr  out  MEM_AW  byte address
mem_req_wdata  out  DATA_WID  write data
mem_rsp_valid  in  1  read data valid, or write acknowledge
mem_rsp_rdata  in  DATA_WID  read data
access_count  out  CNT_W  completed accesses, saturating
stall_cycles  out  CNT_W  cycles with stall=1, saturating
protocol_err  out  1  sticky: response received while no request outstanding

Behaviour:
- Reset (async): all outputs 0 (q0, q1, counters, err, stall, mem_req_*); pending flags cleared; FSM=IDLE. An in-flight request is abandoned; mem_req_valid drops immediately.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1.
- IDLE, at posedge with ce0|ce1:
  - Latch {addr, we, d} of each enabled port; set pend0/pend1.
  - Go to ISSUE0 if pend0, else ISSUE1.
  - stall=1 from the next cycle.
  - If neither ce is set: stay in IDLE, stall=0.
- ISSUE0/ISSUE1 drive the request:
  - mem_req_valid=1, we and wdata from the latched port.
  - mem_req_addr = base_addr + (latched addr << 2), modulo 2^MEM_AW.
  - Fields are held stable, and valid is never retracted, until mem_req_ready=1. On ready go to WAITn, and mem_req_valid=0 from the next cycle.
- WAITn, on mem_rsp_valid:
  - If read: qn <= mem_rsp_rdata.
  - Clear pendn; access_count+1.
  - Next state: from WAIT0 go to ISSUE1 if pend1, else IDLE; from WAIT1 go to IDLE.
- stall is registered. It is 1 in every non-IDLE state, so it rises exactly 1 cycle after capture. It falls in the cycle the FSM re-enters IDLE.
- No new capture occurs while stall=1; ce inputs are ignored.
- Minimum service latency per access: 2 cycles (issue with ready=1, plus response in the next cycle).
- q0/q1 hold their last read value across writes and idle periods. A write never alters q.
- Ordering and hazards:
  - Port 0 is always serviced before port 1, so a port 1 read of the address written by port 0 in the same capture returns the new data.
  - Both ports writing the same address: port 1 value wins.
- mem_rsp_valid outside WAIT0/WAIT1: ignored for data; sets protocol_err, which stays set until reset.
- Counters saturate at 2^CNT_W-1. stall_cycles increments every cycle stall=1.
- mem_req_ready while mem_req_valid=0: no effect.

Decomposition:
- Shared package `scratchpad_pkg`:
  - FSM state enum (IDLE/ISSUE0/WAIT0/ISSUE1/WAIT1).
  - Default width constants ADDR_WID/DATA_WID/MEM_AW.
  - Word-to-byte shift constant (2).
- One sub-module is natural: `sat_counter` (CNT_W, inc, value), instantiated twice for the statistics.

Test Plan:
- Single read:
  - Stimulus: base=0x1000, ce0=1, we0=0, addr0=5; ready=1; response rdata=0xDEADBEEF one cycle later.
  - Response: mem_req_addr=0x1014, we=0; stall high for 2 cycles; q0=0xDEADBEEF; access_count=1.
- Dual ports:
  - Stimulus: ce0 write addr0=3 d0=7, and ce1 read addr1=3, same cycle; memory model returns the stored value.
  - Response: write 0x...0C issued first, then read; q1=7; access_count=2.
- Backpressure:
  - Stimulus: mem_req_ready held 0 for 4 cycles during ISSUE0.
  - Response: mem_req_valid, addr and wdata constant throughout; stall_cycles increases by 4 over the no-wait case.
- Stray response:
  - Stimulus: mem_rsp_valid=1 while IDLE.
  - Response: protocol_err=1 and stays 1; q0/q1 unchanged.
- Reset mid-operation:
  - Stimulus: assert reset while in WAIT1.
  - Response: mem_req_valid, stall and q0/q1 all 0 immediately (no clock); FSM IDLE after deassert; next request serviced normally.
- Address wrap:
  - Stimulus: base=0xFFFF_FFFF_FFFF_FFFC, addr0=1.
  - Response: mem_req_addr=0x0.
